// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: 4-way round-robin arbiter feeding one UART transmitter.
// Ports:
//   clk, rst (sync, active-high)
//   req_valid[3:0], req_data[31:0] in; req_ready[3:0] one-cycle accept out.
//   tx_data, tx_start out; tx_busy in.
//   grant_id, active, timeout_err (sticky) status out.
// Optional: define UART_ARB_STATS_EN to add byte_count[15:0].
module uart_tx_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [1:0]  grant_id,
   output logic        active,
   output logic        timeout_err
`ifdef UART_ARB_STATS_EN
   ,
   output logic [15:0] byte_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER
   } state_t;

   state_t      state, state_d;
   logic [1:0]  ptr, ptr_d;
   logic [15:0] cnt, cnt_d;
   logic [3:0]  ready_d;
   logic [7:0]  data_d;
   logic [1:0]  gid_d;
   logic        start_d;
   logic        err_d;
   logic        done;

   logic        found;
   logic [1:0]  win;
   logic [1:0]  cand;

   // Search starts one past the last winner.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      cand  = ptr;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d = state;
      start_d = tx_start;
      ready_d = '0;
      data_d  = tx_data;
      gid_d   = grant_id;
      ptr_d   = ptr;
      err_d   = timeout_err;
      cnt_d   = cnt;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (found && !tx_busy) begin
               state_d      = REQ;
               start_d      = 1'b1;
               ready_d[win] = 1'b1;
               data_d       = req_data[{win, 3'b000} +: 8];
               gid_d        = win;
               ptr_d        = win;
               cnt_d        = '0;
            end
         end
         REQ: begin
            if (tx_busy) begin
               start_d = 1'b0;
               state_d = XFER;
               cnt_d   = '0;
            end else if (cnt == 16'(ACK_TIMEOUT - 1)) begin
               // Transmitter never answered: drop the byte.
               start_d = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
         XFER: begin
            if (!tx_busy) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tx_start    <= 1'b0;
         req_ready   <= '0;
         tx_data     <= '0;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
         ptr         <= 2'd3;
      end else begin
         state       <= state_d;
         tx_start    <= start_d;
         req_ready   <= ready_d;
         tx_data     <= data_d;
         grant_id    <= gid_d;
         active      <= (state_d != IDLE);
         timeout_err <= err_d;
         cnt         <= cnt_d;
         ptr         <= ptr_d;
      end
   end

`ifdef UART_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_count <= '0;
      end else if (done) begin
         byte_count <= byte_count + 16'd1;
      end
   end
`else
   logic unused_done;
   assign unused_done = done;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;
`ifdef UART_ARB_STATS_EN
   logic [15:0] byte_count;
`endif

   uart_tx_arbiter #(
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_id   (grant_id),
      .active     (active),
      .timeout_err(timeout_err)
`ifdef UART_ARB_STATS_EN
      ,
      .byte_count (byte_count)
`endif
   );

   always #5 clk = ~clk;

   int vec = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_act"}, active, 0);
      chk({tag, "_start"}, tx_start, 0);
      chk({tag, "_rdy"}, req_ready, 0);
      chk({tag, "_data"}, tx_data, 0);
      chk({tag, "_gid"}, grant_id, 0);
      chk({tag, "_err"}, timeout_err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tx_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready != 0) ok = 1'b1;
      end
      chk("grant_seen", 32'(ok), 1);
   endtask

   function automatic logic [1:0] rr_pick(input logic [1:0] lst,
                                          input logic [3:0] v);
      bit f = 1'b0;
      int idx;
      rr_pick = lst + 2'd1;
      for (int i = 1; i <= 4; i++) begin
         idx = (int'(lst) + i) % 4;
         if (!f && v[idx]) begin
            f = 1'b1;
            rr_pick = 2'(idx);
         end
      end
   endfunction

   logic [7:0] q[4][$];
   logic [7:0] tmp;
   logic [1:0] last, w;
   int xs, k, d, l, lim, idle_n, ns, done_n;
   bit exp_err, ok;

   initial begin
      // reset values
      @(negedge clk);
      @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;

      // single requester
      req_valid = 4'b0001;
      req_data = 32'h0000_00A5;
      @(negedge clk);
      chk("s_rdy", req_ready, 4'b0001);
      chk("s_start", tx_start, 1);
      chk("s_data", tx_data, 8'hA5);
      chk("s_gid", grant_id, 0);
      chk("s_act", active, 1);
      req_valid = '0;
      @(negedge clk);
      chk("s_rdy_fall", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         chk("s_hold", tx_start, 1);
         @(negedge clk);
      end
      chk("s_hold_data", tx_data, 8'hA5);
      tx_busy = 1'b1;
      @(negedge clk);
      chk("s_start_drop", tx_start, 0);
      chk("s_xfer_act", active, 1);
      @(negedge clk);
      chk("s_act_busy", active, 1);
      tx_busy = 1'b0;
      @(negedge clk);
      chk("s_act_fall", active, 0);

      // fairness
      do_reset();
      req_valid = 4'hF;
      req_data = 32'h4332_2110;
      for (int g = 0; g < 5; g++) begin
         wait_ready(ok);
         chk("f_gid", grant_id, g % 4);
         chk("f_rdy", req_ready, 4'b1 << (g % 4));
         chk("f_data", tx_data, 8'h10 + 8'h11 * (g % 4));
         tx_busy = 1'b1;
         @(negedge clk);
         chk("f_pulse", req_ready, 0);
         tx_busy = 1'b0;
      end

      // timeout
      do_reset();
      req_valid = 4'b0100;
      req_data = 32'h0077_0000;
      @(negedge clk);
      chk("t_rdy", req_ready, 4'b0100);
      chk("t_gid", grant_id, 2);
      chk("t_data", tx_data, 8'h77);
      req_valid = '0;
      ns = int'(tx_start);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (tx_start) ns++;
      end
      chk("t_len", ns, TO);
      chk("t_err", timeout_err, 1);
      chk("t_act", active, 0);
      repeat (5) @(negedge clk);
      chk("t_sticky", timeout_err, 1);
      do_reset();
      chk("t_rst_err", timeout_err, 0);

      // busy at idle
      tx_busy = 1'b1;
      req_valid = 4'b0010;
      req_data = 32'h0000_5A00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("b_rdy", req_ready, 0);
         chk("b_start", tx_start, 0);
      end
      tx_busy = 1'b0;
      @(negedge clk);
      chk("b_rdy_go", req_ready, 4'b0010);
      chk("b_gid", grant_id, 1);
      chk("b_data", tx_data, 8'h5A);
      req_valid = '0;

      // reset mid-transfer
      do_reset();
      req_valid = 4'b0100;
      req_data = 32'h0099_0000;
      @(negedge clk);
      chk("m_rdy", req_ready, 4'b0100);
      req_valid = '0;
      tx_busy = 1'b1;
      @(negedge clk);
      chk("m_xfer", active, 1);
      rst = 1'b1;
      req_valid = 4'b0101;
      req_data = 32'h00CC_00BB;
      @(negedge clk);
      chk_reset("m_rst");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("m_hold", req_ready, 0);
      end
      tx_busy = 1'b0;
      @(negedge clk);
      chk("m_rdy0", req_ready, 4'b0001);
      chk("m_data", tx_data, 8'hBB);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      last = 2'd3;
      xs = 0;
      k = 0;
      d = 0;
      l = 0;
      lim = 0;
      idle_n = 0;
      done_n = 0;
      exp_err = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            w = rr_pick(last, req_valid);
            chk("r_rdy", req_ready, 4'b1 << w);
            chk("r_gid", grant_id, w);
            if (q[w].size() > 0) begin
               chk("r_data", tx_data, q[w][0]);
               tmp = q[w].pop_front();
            end
            last = w;
            idle_n = 0;
            xs = 1;
            k = 0;
            d = $urandom_range(0, 10);
            l = $urandom_range(1, 4);
            lim = (d < TO) ? d : TO - 1;
         end else if (xs != 0) begin
            k++;
         end
         if (xs != 0) chk("r_start", tx_start, 32'(k <= lim));
         if (xs == 1 && d < TO && k == d) begin
            xs = 2;
         end else if (xs == 1 && d >= TO && k == TO) begin
            exp_err = 1'b1;
            chk("r_to_act", active, 0);
            xs = 0;
         end
         if (xs == 2) begin
            chk("r_act", active, 32'(k <= d + l));
            if (k == d + l + 1) begin
               xs = 0;
               done_n++;
            end
         end
         chk("r_err", timeout_err, 32'(exp_err));
         tx_busy = (xs == 2) && (k < d + l);
         for (int i = 0; i < 4; i++) begin
            if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
               q[i].push_back(8'($urandom));
         end
         for (int i = 0; i < 4; i++) begin
            req_valid[i] = (q[i].size() != 0);
            req_data[8*i +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
         end
         if (req_valid != 0 && xs == 0) idle_n++;
         if (idle_n > 30) begin
            chk("r_stall", 0, 1);
            idle_n = 0;
         end
      end
`ifdef UART_ARB_STATS_EN
      chk("r_count", byte_count, 16'(done_n));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1024, is the maximum number of clk cycles tx_start is held waiting for tx_busy to rise; legal range is 2..65535.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester byte-pending flag, where bit i belongs to requester i.
REQ-005 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 req_ready  output  4  one-hot, one-cycle accept pulse per requester.
REQ-007 tx_data  output  8  byte driven to the transmitter data input.
REQ-008 tx_start  output  1  transmit request to the transmitter.
REQ-009 tx_busy  input  1  transmitter busy flag.
REQ-010 grant_id  output  2  index of the current or most recent winner.
REQ-011 active  output  1  high whenever the state is not IDLE.
REQ-012 timeout_err  output  1  sticky flag indicating the transmitter failed to accept a byte.

Function
REQ-013 All outputs SHALL be registered, and the block SHALL use a three-state FSM: IDLE, REQ, XFER.
REQ-014 In IDLE, a grant SHALL be made only when req_valid is non-zero and tx_busy is 0.
REQ-015 If tx_busy is 1 in IDLE, the block SHALL stay in IDLE and issue no grant, regardless of req_valid.
REQ-016 Arbitration SHALL be round-robin.
- The search starts at (last winner + 1) mod 4.
- After reset, the pointer SHALL favour requester 0 first.
REQ-017 On a grant in IDLE cycle N:
- tx_data, grant_id and the pointer SHALL update at the edge ending cycle N.
- The state SHALL move to REQ.
- tx_start=1 and req_ready[winner]=1 SHALL appear in cycle N+1.
- req_ready SHALL fall in cycle N+2.
REQ-018 A requester SHALL hold req_valid and req_data stable until its req_ready pulse; data is captured from the grant cycle.
REQ-019 In REQ, tx_start and tx_data SHALL remain stable until tx_busy is sampled 1.
- On that edge: tx_start goes to 0, the state moves to XFER, and the timeout counter clears.
REQ-020 In REQ, a 16-bit counter SHALL increment each cycle.
- If it reaches ACK_TIMEOUT-1 with tx_busy still 0: tx_start goes to 0, timeout_err is set to 1, and the state moves to IDLE.
- The byte is dropped and not retried.
REQ-021 In XFER, the block SHALL wait for tx_busy=0, then return to IDLE.
- The earliest new grant is the cycle after returning to IDLE.
REQ-022 If tx_busy rises and falls within REQ before being sampled high, the block SHALL time out per REQ-020.
REQ-023 grant_id SHALL hold its value in IDLE; active SHALL equal (state != IDLE).
REQ-024 timeout_err SHALL clear only on rst.

Reset
REQ-025 While rst=1, the block SHALL force these values on the next edge, which take priority over all other events:
- state = IDLE
- tx_start = 0
- req_ready = 0
- tx_data = 0x00
- grant_id = 0
- active = 0
- timeout_err = 0
- counter = 0
- round-robin pointer = 3, so requester 0 wins first.
REQ-026 On reset mid-transfer, the block SHALL not grant again until tx_busy is 0 (per REQ-015).

Configuration
REQ-027 When UART_ARB_STATS_EN is defined:
- A 16-bit output byte_count SHALL exist, reset to 0.
- It increments by 1 on every XFER->IDLE transition and wraps from 0xFFFF to 0x0000.
- Timeouts are not counted.
REQ-028 When UART_ARB_STATS_EN is undefined, the byte_count port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 Single requester: req_valid=0001, req_data[7:0]=0xA5 -> req_ready=0001 for one cycle, tx_data=0xA5, tx_start held until tx_busy=1, active falls one cycle after tx_busy falls.
REQ-030 Fairness: req_valid=1111 held, bytes 0x10/0x21/0x32/0x43 -> grant_id sequence 0,1,2,3,0 and each req_ready pulses exactly once per byte.
REQ-031 Timeout: ACK_TIMEOUT=8, tx_busy tied 0, req_valid=0100 -> tx_start high for exactly 8 cycles, then timeout_err=1 and state IDLE; timeout_err stays 1 until rst.
REQ-032 Busy at idle: tx_busy=1, req_valid=0010 -> no req_ready and tx_start=0 until tx_busy=0, then grant to requester 1 on the next cycle.
REQ-033 Reset mid-XFER: rst pulsed during XFER with tx_busy=1 -> all outputs reset next edge; the next grant goes to requester 0 only after tx_busy=0.
REQ-034 Stats (UART_ARB_STATS_EN): 65537 completed bytes -> byte_count=0x0001; one timeout -> count unchanged.
